// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arbiter
//  Description : Shares one AXI read address/data channel pair between the
//                instruction-fetch requester (i_*) and the data/uncached-load
//                requester (d_*). One burst is outstanding at a time. The
//                arbiter drives fixed AR sideband fields, routes R beats to
//                the granted requester with zero latency, and raises a sticky
//                len_err flag when rlast disagrees with the requested length.
//  Ports       : aclk, rst (sync, active high)
//                i_req_* / d_req_*   : request valid/ready, addr, len, size
//                i_resp_* / d_resp_* : beat valid, data, last
//                ar*                 : AXI read address channel (master side)
//                r*                  : AXI read data channel (master side)
//                len_err             : sticky burst-length mismatch flag
//  Options     : AXI_RD_ARB_RR_EN - when defined, simultaneous requests are
//                granted round-robin; otherwise data wins over instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] ID_I   = 4'd0,
  parameter logic [3:0] ID_D   = 4'd1
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [7:0]        i_req_len,
  input  logic [2:0]        i_req_size,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_resp_last,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [7:0]        d_req_len,
  input  logic [2:0]        d_req_size,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_last,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              len_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_gnt_i;
  logic                r_gnt_d;
  logic [7:0]          r_beats;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_len_err;
  logic [3:0]          r_arid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic [2:0]          r_arsize;

  logic w_idle;
  logic w_data;
  logic w_prio_d;
  logic w_pick_d;
  logic w_pick_i;
  logic w_len_bad;
  logic w_unused_ok;

  // Response id and status are deliberately ignored.
  assign w_unused_ok = ^{rid, rresp};

  // Gating with rst keeps req_ready low while reset is applied.
  assign w_idle = (r_state == S_IDLE) && !rst;
  assign w_data = (r_state == S_DATA);

`ifdef AXI_RD_ARB_RR_EN
  logic r_last_d;  // most recent winner: 1 = data, 0 = instruction
  assign w_prio_d = !r_last_d;
`else
  assign w_prio_d = 1'b1;
`endif

  assign w_pick_d = w_idle && d_req_valid && (w_prio_d || !i_req_valid);
  assign w_pick_i = w_idle && i_req_valid && !w_pick_d;

  assign i_req_ready = w_pick_i;
  assign d_req_ready = w_pick_d;

  // Beats pass straight through to whichever requester owns the burst.
  assign i_resp_valid = w_data && r_gnt_i && rvalid;
  assign i_resp_data  = rdata;
  assign i_resp_last  = w_data && r_gnt_i && rlast;
  assign d_resp_valid = w_data && r_gnt_d && rvalid;
  assign d_resp_data  = rdata;
  assign d_resp_last  = w_data && r_gnt_d && rlast;

  // A beat is bad when rlast and "counter reached zero" disagree.
  assign w_len_bad = rlast != (r_beats == 8'd0);

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;
  assign len_err = r_len_err;

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt_i   <= 1'b0;
      r_gnt_d   <= 1'b0;
      r_beats   <= 8'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_len_err <= 1'b0;
      r_arid    <= 4'd0;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
`ifdef AXI_RD_ARB_RR_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_d || w_pick_i) begin
            r_arid    <= w_pick_d ? ID_D : ID_I;
            r_araddr  <= w_pick_d ? d_req_addr : i_req_addr;
            r_arlen   <= w_pick_d ? d_req_len  : i_req_len;
            r_arsize  <= w_pick_d ? d_req_size : i_req_size;
            r_beats   <= w_pick_d ? d_req_len  : i_req_len;
            r_gnt_d   <= w_pick_d;
            r_gnt_i   <= !w_pick_d;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
`ifdef AXI_RD_ARB_RR_EN
            r_last_d  <= w_pick_d;
`endif
          end
        end
        S_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (rvalid) begin
            r_beats <= r_beats - 8'd1;
            if (w_len_bad) begin
              r_len_err <= 1'b1;
            end
            if (rlast) begin
              r_rready <= 1'b0;
              r_gnt_i  <= 1'b0;
              r_gnt_d  <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
